// File: rtl/bus_grant_ctrl.sv
// Shared-bus grant controller: fixed-priority or round-robin arbitration.
// Each grant is held until done/req-drop/hold-limit, then one dead cycle follows.
module bus_grant_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout
);

    localparam int unsigned OW = $clog2(N);
    localparam int unsigned HW = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_ptr_nxt;
    logic [HW-1:0]   r_cnt;
    logic [HW-1:0]   w_cnt_nxt;
    logic            r_busy;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            w_found;
    logic [OW-1:0]   w_win;
    logic            w_rel_norm;
    logic            w_rel_to;

    // Winner search: lowest index in fixed mode, from r_ptr+1 upward in RR mode.
    always_comb begin
        int unsigned   idx;
        logic [OW-1:0] cand;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx  = mode ? ((32'(r_ptr) + 32'd1 + i) % N) : i;
            cand = OW'(idx);
            if (!w_found && req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    assign w_rel_norm = done[r_owner] | ~req[r_owner];
    assign w_rel_to   = (r_cnt == HW'(HOLD_MAX - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_GAP: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_owner_nxt      = w_win;
                    w_ptr_nxt        = w_win;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_GRANT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_rel_norm || w_rel_to) begin
                    w_gnt_nxt     = '0;
                    w_state_nxt   = S_GAP;
                    // Forced revoke is flagged only when no normal release coincides.
                    w_timeout_nxt = w_rel_to & ~w_rel_norm;
                end else begin
                    w_cnt_nxt = r_cnt + HW'(1);
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= OW'(N - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= |w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign owner   = r_owner;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Directed, table-driven bench for bus_grant_ctrl (N=4, HOLD_MAX=4).
module tb_bus_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       timeout;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       to;
    } vec_t;

    vec_t vq[$];

    bus_grant_ctrl #(.N(4), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .done(done),
        .gnt(gnt), .busy(busy), .owner(owner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic m, input logic [3:0] q, input logic [3:0] d);
        @(negedge clk);
        rst  = r;
        mode = m;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eo, input logic et);
        n_vec++;
        if (gnt !== eg || busy !== (|eg) || owner !== eo || timeout !== et) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b busy=%b owner=%0d timeout=%b, want gnt=%b busy=%b owner=%0d timeout=%b",
                     name, gnt, busy, owner, timeout, eg, |eg, eo, et);
        end
    endtask

    task automatic step(input string name, input logic r, input logic m, input logic [3:0] q,
                        input logic [3:0] d, input logic [3:0] eg, input logic [1:0] eo, input logic et);
        apply(r, m, q, d);
        check(name, eg, eo, et);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; req = '0; done = '0;

        // {rst, mode, req, done} -> {gnt, owner, timeout}
        vq.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}); // reset
        vq.push_back('{1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0}); // fixed: grant 0
        vq.push_back('{1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0}); // done -> gap
        vq.push_back('{1'b0, 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b0}); // 1110 -> 1
        vq.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0}); // drop
        vq.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0}); // idle
        vq.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}); // reset before RR
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0}); // RR: 0
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0}); // RR: 1
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0}); // RR: 2
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0}); // RR: 3
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0}); // RR wraps to 0
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0}); // gap -> idle

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].mode, vq[i].req, vq[i].done);
            check($sformatf("tbl[%0d]", i), vq[i].gnt, vq[i].owner, vq[i].to);
        end

        // Hold limit: four grant cycles, forced revoke, regrant.
        for (int i = 0; i < 4; i++)
            step($sformatf("to_hold[%0d]", i), 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        step("to_pulse", 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1);
        step("to_regrant", 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            step($sformatf("to2_hold[%0d]", i), 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
        step("to2_done_at_limit", 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0);
        step("to2_idle", 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0);

        // Foreign done ignored; owner request drop releases.
        step("drop_grant", 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
        step("foreign_done", 1'b0, 1'b0, 4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b0);
        step("drop_release", 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd1, 1'b0);
        step("gap_grant3", 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
        step("drop3", 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0);
        step("idle_done_ign", 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0);

        // Mode switch during grant, then reset mid-grant.
        step("ms_grant0", 1'b0, 1'b0, 4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b0);
        step("ms_switch", 1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b0);
        step("ms_done", 1'b0, 1'b1, 4'b0111, 4'b0001, 4'b0000, 2'd0, 1'b0);
        step("ms_rr_next", 1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b0);
        step("ms_hold", 1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b0);
        step("mid_reset", 1'b1, 1'b1, 4'b0111, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step("post_reset_rr", 1'b0, 1'b1, 4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
